// File: rtl/sync_mem_slave.sv
// Clocked memory target: self-initialises after reset, then serves one request per cycle
// with a fixed read latency and one-cycle error pulses on out-of-range accesses.
module sync_mem_slave #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 2 ** ADDR_W,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned INIT_SHIFT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              read,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              err
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              rd_acc;
    logic              wr_oor;
    logic              in_range;
    logic [DATA_W-1:0] rd_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [RD_LAT-1:0] pipe_vld_q;
    logic [RD_LAT-1:0] pipe_oor_q;
    logic [DATA_W-1:0] pipe_data_q [RD_LAT];

    logic              wr_err_q;
    logic [DATA_W-1:0] data_q;
    logic              data_valid_q;
    logic              err_q;

    assign ready    = (state_q == StRun);
    assign accept   = enable & ready;
    assign rd_acc   = accept & read;
    assign in_range = 32'(addr) < DEPTH;
    assign wr_oor   = accept & ~read & ~in_range;
    // Out-of-range reads carry zero down the pipe so the output stage needs no extra mux.
    assign rd_word  = in_range ? mem[addr] : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = wdata;
        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = DATA_W'(cnt_q >> INIT_SHIFT);
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                mem_we = accept & ~read & in_range;
            end
            default: begin
                state_d = StInit;
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read data stages need no reset: only the valid bits decide what reaches the output.
    always_ff @(posedge clk) begin
        pipe_data_q[0] <= rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_data_q[i] <= pipe_data_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q   <= '0;
            pipe_oor_q   <= '0;
            wr_err_q     <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pipe_vld_q[0] <= rd_acc;
            pipe_oor_q[0] <= ~in_range;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_oor_q[i] <= pipe_oor_q[i-1];
            end
            wr_err_q     <= wr_oor;
            data_valid_q <= pipe_vld_q[RD_LAT-1];
            err_q        <= wr_err_q | (pipe_vld_q[RD_LAT-1] & pipe_oor_q[RD_LAT-1]);
            if (pipe_vld_q[RD_LAT-1]) begin
                data_q <= pipe_data_q[RD_LAT-1];
            end
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sync_mem_slave.sv
// Self-checking bench for sync_mem_slave: directed scenarios plus random traffic, all
// compared each cycle against a queue-based reference model.
module tb_sync_mem_slave;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
    localparam int LAT   = 2;
    localparam int SH    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          read;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          err;

    always #5 clk = ~clk;

    sync_mem_slave #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .DEPTH     (DEPTH),
        .RD_LAT    (LAT),
        .INIT_SHIFT(SH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .read      (read),
        .addr      (addr),
        .wdata     (wdata),
        .ready     (ready),
        .data      (data),
        .data_valid(data_valid),
        .err       (err)
    );

    typedef struct {
        int due;
        int value;
        bit oor;
    } rd_t;

    int  n_checks;
    int  n_fail;

    // Reference model state
    int  cyc;
    bit  m_ready;
    int  m_cnt;
    int  m_mem[256];
    rd_t pend[$];
    int  wr_err_due;
    bit  e_dv;
    bit  e_err;
    int  e_data;
    bit  dv_seen;
    bit  err_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge();
        rd_t r;
        cyc++;
        e_dv  = 1'b0;
        e_err = 1'b0;
        if (rst) begin
            m_ready    = 1'b0;
            m_cnt      = 0;
            pend.delete();
            wr_err_due = -1;
            e_data     = 0;
            return;
        end
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r      = pend.pop_front();
            e_dv   = 1'b1;
            e_data = r.oor ? 0 : r.value;
            if (r.oor) e_err = 1'b1;
        end
        if (wr_err_due == cyc) e_err = 1'b1;
        if (m_ready && enable) begin
            if (read) begin
                r.due   = cyc + LAT;
                r.oor   = int'(addr) >= DEPTH;
                r.value = r.oor ? 0 : m_mem[addr];
                pend.push_back(r);
            end else if (int'(addr) < DEPTH) begin
                m_mem[addr] = int'(wdata);
            end else begin
                wr_err_due = cyc + 1;
            end
        end
        if (!m_ready) begin
            m_mem[m_cnt] = (m_cnt >> SH) & ((1 << DW) - 1);
            m_cnt++;
            if (m_cnt == DEPTH) m_ready = 1'b1;
        end
    endtask

    // Drive inputs, let one posedge happen, then compare all outputs on the falling edge.
    task automatic tick(input bit r, input bit en, input bit rd, input int a, input int wd);
        rst    = r;
        enable = en;
        read   = rd;
        addr   = AW'(a);
        wdata  = DW'(wd);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("ready", 32'(ready), 32'(m_ready));
        check("data_valid", 32'(data_valid), 32'(e_dv));
        check("data", 32'(data), e_data);
        check("err", 32'(err), 32'(e_err));
        if (data_valid) dv_seen = 1'b1;
        if (err) err_seen = 1'b1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 0, 0);
        tick(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // Counts the cycles with ready low after reset, including the one right after the rst edge.
    task automatic wait_ready(input bit en, input bit rd, input int a, input int wd,
                              output int n);
        n = 1;
        while (!ready && n < 1000) begin
            tick(1'b0, en, rd, a, wd);
            if (!ready) n++;
        end
    endtask

    task automatic read_check(input string tag, input int a, input int exp);
        tick(1'b0, 1'b1, 1'b1, a, 0);
        idle();
        idle();
        check({tag, "_dv"}, 32'(data_valid), 32'd1);
        check(tag, 32'(data), exp);
    endtask

    initial begin
        int n;
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        m_ready    = 1'b0;
        m_cnt      = 0;
        wr_err_due = -1;
        e_data     = 0;
        dv_seen    = 1'b0;
        err_seen   = 1'b0;

        // Reset and self-initialisation
        do_reset();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        wait_ready(1'b0, 1'b0, 0, 0, n);
        check("init_len", n, DEPTH);
        read_check("rd70", 70, 35);
        read_check("rd150", 150, 75);

        // Back-to-back reads
        tick(1'b0, 1'b1, 1'b1, 5, 0);
        tick(1'b0, 1'b1, 1'b1, 6, 0);
        tick(1'b0, 1'b1, 1'b1, 7, 0);
        check("b2b0", 32'(data), 32'd2);
        check("b2b0_dv", 32'(data_valid), 32'd1);
        idle();
        check("b2b1", 32'(data), 32'd3);
        check("b2b1_dv", 32'(data_valid), 32'd1);
        idle();
        check("b2b2", 32'(data), 32'd3);
        check("b2b2_dv", 32'(data_valid), 32'd1);
        idle();
        check("b2b_hold", 32'(data), 32'd3);
        check("b2b_end_dv", 32'(data_valid), 32'd0);

        // Read-after-write
        tick(1'b0, 1'b1, 1'b0, 5, 'hA5);
        read_check("raw5", 5, 'hA5);
        read_check("rd4", 4, 2);

        // Out-of-range read and write
        tick(1'b0, 1'b1, 1'b1, 210, 0);
        idle();
        idle();
        check("oor_rd_dv", 32'(data_valid), 32'd1);
        check("oor_rd_err", 32'(err), 32'd1);
        check("oor_rd_data", 32'(data), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 250, 'h11);
        idle();
        check("oor_wr_err", 32'(err), 32'd1);
        check("oor_wr_dv", 32'(data_valid), 32'd0);
        idle();
        check("oor_wr_err_end", 32'(err), 32'd0);
        read_check("rd50", 50, 25);

        // Reset with reads in flight
        tick(1'b0, 1'b1, 1'b1, 70, 0);
        tick(1'b0, 1'b1, 1'b1, 71, 0);
        dv_seen = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 0, 0);
        check("flush_ready", 32'(ready), 32'd0);
        wait_ready(1'b0, 1'b0, 0, 0, n);
        check("reinit_len", n, DEPTH);
        check("flush_no_dv", 32'(dv_seen), 32'd0);
        read_check("reinit5", 5, 2);

        // Requests during INIT are dropped
        do_reset();
        err_seen = 1'b0;
        wait_ready(1'b1, 1'b0, 3, 'hFF, n);
        check("init_drop_len", n, DEPTH);
        read_check("rd3", 3, 1);
        check("init_no_err", 32'(err_seen), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(0, 399) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 255), $urandom_range(0, 255));
        end
        repeat (LAT + 2) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
